// File: rtl/traffic_phase_ctrl_if.sv
// Sensor, timer and lamp signals of the intersection controller.
// The bench drives through the master modport and the controller uses the slave modport.
interface traffic_phase_ctrl_if;
    logic       car;
    logic       ped_req;
    logic       night;
    logic       tick;
    logic       ts;
    logic       tl;
    logic       st;
    logic [1:0] hl;
    logic [1:0] fl;
    logic       walk;
    logic [2:0] state_o;

    modport master (
        output car, ped_req, night, tick, ts, tl,
        input  st, hl, fl, walk, state_o
    );

    modport slave (
        input  car, ped_req, night, tick, ts, tl,
        output st, hl, fl, walk, state_o
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Highway/farm-road intersection controller with pedestrian service and night flashing.
// Define PED_WALK_EN to include the pedestrian request latch and walk lamp.
module traffic_phase_ctrl #(
    parameter int GUARD     = 2,
    parameter int FLASH_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_phase_ctrl_if.slave  bus
);
    localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
    localparam int DW = 4;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD);
    localparam logic [GW-1:0] GUARD_ZERO = GW'(0);
    localparam logic [GW-1:0] GUARD_ONE  = GW'(1);
    localparam logic [DW-1:0] DIV_ZERO   = DW'(0);
    localparam logic [DW-1:0] DIV_ONE    = DW'(1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(FLASH_DIV - 1);

    typedef enum logic [2:0] {
        S_HG     = 3'd0,
        S_HY     = 3'd1,
        S_FG     = 3'd2,
        S_FY     = 3'd3,
        S_ALLRED = 3'd4,
        S_FLASH  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic          st_q, st_d;
    logic [1:0]    hl_q, hl_d;
    logic [1:0]    fl_q, fl_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [DW-1:0] div_q, div_d;
    logic          phase_q, phase_d;
    logic          ts_e_s;
    logic          tl_e_s;
    logic          hg_req_s;
    logic          fg_hold_s;
    logic          change_s;

`ifdef PED_WALK_EN
    logic          ped_q, ped_d;
    logic          walk_q, walk_d;
    logic          hy_to_fg_s;
`else
    logic          unused_ped_s;
    assign unused_ped_s = bus.ped_req;
`endif

    // {hl, fl} for a state; unknown codes show all-red
    function automatic logic [3:0] light_code(input state_e s, input logic ph);
        logic [3:0] code;
        case (s)
            S_HG:     code = 4'b01_11;
            S_HY:     code = 4'b10_11;
            S_FG:     code = 4'b11_01;
            S_FY:     code = 4'b11_10;
            S_ALLRED: code = 4'b11_11;
            S_FLASH:  code = ph ? 4'b10_11 : 4'b00_00;
            default:  code = 4'b11_11;
        endcase
        return code;
    endfunction

    // Next-state selection; timer flags count only once the settle window has passed
    always_comb begin
        state_d = state_q;
        ts_e_s  = bus.ts & (guard_q == GUARD_ZERO);
        tl_e_s  = bus.tl & (guard_q == GUARD_ZERO);
`ifdef PED_WALK_EN
        hg_req_s  = bus.car | ped_q;
        fg_hold_s = walk_q;
`else
        hg_req_s  = bus.car;
        fg_hold_s = 1'b0;
`endif
        case (state_q)
            S_HG: begin
                if (bus.night || (tl_e_s && hg_req_s)) state_d = S_HY;
                else                                   state_d = S_HG;
            end
            S_HY: begin
                if (ts_e_s && bus.night) state_d = S_FLASH;
                else if (ts_e_s)         state_d = S_FG;
                else                     state_d = S_HY;
            end
            S_FG: begin
                if (bus.night || tl_e_s)                        state_d = S_FY;
                else if (ts_e_s && !bus.car && !fg_hold_s)      state_d = S_FY;
                else                                            state_d = S_FG;
            end
            S_FY: begin
                if (ts_e_s && bus.night) state_d = S_FLASH;
                else if (ts_e_s)         state_d = S_HG;
                else                     state_d = S_FY;
            end
            S_FLASH: begin
                if (!bus.night) state_d = S_ALLRED;
                else            state_d = S_FLASH;
            end
            S_ALLRED: begin
                if (bus.night)   state_d = S_FLASH;
                else if (ts_e_s) state_d = S_HG;
                else             state_d = S_ALLRED;
            end
            default: state_d = S_HG;
        endcase
    end

    // Restart strobe, settle window, flash divider, pedestrian latch and lamp decode
    always_comb begin
        change_s = (state_d != state_q);
        st_d     = change_s;

        if (change_s)                    guard_d = GUARD_LOAD;
        else if (guard_q != GUARD_ZERO)  guard_d = guard_q - GUARD_ONE;
        else                             guard_d = GUARD_ZERO;

        div_d   = div_q;
        phase_d = phase_q;
        if (change_s) begin
            div_d   = DIV_ZERO;
            phase_d = 1'b0;
        end else if ((state_q == S_FLASH) && bus.tick) begin
            if (div_q == DIV_LAST) begin
                div_d   = DIV_ZERO;
                phase_d = ~phase_q;
            end else begin
                div_d   = div_q + DIV_ONE;
                phase_d = phase_q;
            end
        end else begin
            div_d   = div_q;
            phase_d = phase_q;
        end

`ifdef PED_WALK_EN
        hy_to_fg_s = (state_q == S_HY) && (state_d == S_FG);
        if (state_q == S_FLASH) ped_d = 1'b0;
        else if (hy_to_fg_s)    ped_d = 1'b0;
        else                    ped_d = ped_q | bus.ped_req;

        // A request arriving in the very cycle of the HY->FG hand-over is served now
        if (hy_to_fg_s)             walk_d = ped_q | bus.ped_req;
        else if (state_d == S_FG)   walk_d = walk_q;
        else                        walk_d = 1'b0;
`endif

        {hl_d, fl_d} = light_code(state_d, phase_d);
    end

    // Controller state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_HG;
            st_q    <= 1'b1;
            hl_q    <= 2'b01;
            fl_q    <= 2'b11;
            guard_q <= GUARD_LOAD;
            div_q   <= DIV_ZERO;
            phase_q <= 1'b0;
`ifdef PED_WALK_EN
            ped_q   <= 1'b0;
            walk_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            hl_q    <= hl_d;
            fl_q    <= fl_d;
            guard_q <= guard_d;
            div_q   <= div_d;
            phase_q <= phase_d;
`ifdef PED_WALK_EN
            ped_q   <= ped_d;
            walk_q  <= walk_d;
`endif
        end
    end

    assign bus.st      = st_q;
    assign bus.hl      = hl_q;
    assign bus.fl      = fl_q;
    assign bus.state_o = state_q;
`ifdef PED_WALK_EN
    assign bus.walk    = walk_q;
`else
    assign bus.walk    = 1'b0;
`endif
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model; follows PED_WALK_EN when defined.
module tb_traffic_phase_ctrl;
    localparam int GUARD     = 2;
    localparam int FLASH_DIV = 1;

    logic clk = 1'b0;
    logic rst_n;
    traffic_phase_ctrl_if bus();

    traffic_phase_ctrl #(.GUARD(GUARD), .FLASH_DIV(FLASH_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: state code, edges since last change, FLASH ticks since entry, pedestrian bits
    int m_state = 0;
    int m_age   = 0;
    int m_ticks = 0;
    bit m_st    = 1'b1;
    bit m_ped   = 1'b0;
    bit m_walk  = 1'b0;

    function automatic logic [3:0] road_lights(input int s, input int ticks);
        case (s)
            0:       return 4'b0111;
            1:       return 4'b1011;
            2:       return 4'b1101;
            3:       return 4'b1110;
            4:       return 4'b1111;
            5:       return (((ticks / FLASH_DIV) % 2) == 1) ? 4'b1011 : 4'b0000;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [8:0] exp_v();
        logic [2:0] sc;
        sc = m_state[2:0];
        return {sc, m_st, road_lights(m_state, m_ticks), m_walk};
    endfunction

    function automatic logic [8:0] dut_v();
        return {bus.state_o, bus.st, bus.hl, bus.fl, bus.walk};
    endfunction

    task automatic model_step();
        int nxt;
        bit tse, tle, req, changed, ped_old;
        if (!rst_n) begin
            m_state = 0; m_st = 1'b1; m_age = 0; m_ticks = 0; m_ped = 1'b0; m_walk = 1'b0;
            return;
        end
        tse = bus.ts && (m_age >= GUARD);
        tle = bus.tl && (m_age >= GUARD);
`ifdef PED_WALK_EN
        req = bus.car || m_ped;
`else
        req = bus.car;
`endif
        nxt = m_state;
        case (m_state)
            0: if (bus.night || (tle && req)) nxt = 1;
            1: if (tse) nxt = bus.night ? 5 : 2;
            2: if (bus.night || tle || (tse && !bus.car && !m_walk)) nxt = 3;
            3: if (tse) nxt = bus.night ? 5 : 0;
            4: if (bus.night) nxt = 5; else if (tse) nxt = 0;
            5: if (!bus.night) nxt = 4;
            default: nxt = 0;
        endcase
        changed = (nxt != m_state);
`ifdef PED_WALK_EN
        ped_old = m_ped;
        if (m_state == 5)                  m_ped = 1'b0;
        else if (m_state == 1 && nxt == 2) m_ped = 1'b0;
        else if (bus.ped_req)              m_ped = 1'b1;
        if (nxt != 2)          m_walk = 1'b0;
        else if (m_state == 1) m_walk = ped_old || bus.ped_req;
`else
        ped_old = 1'b0;
`endif
        if (changed) begin
            m_ticks = 0;
            m_age   = 0;
        end else begin
            if (m_state == 5 && bus.tick) m_ticks++;
            if (m_age < 1000) m_age++;
        end
        m_st    = changed;
        m_state = nxt;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit car, input bit ped, input bit night,
                         input bit tick, input bit ts, input bit tl);
        bus.car = car; bus.ped_req = ped; bus.night = night;
        bus.tick = tick; bus.ts = ts; bus.tl = tl;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (GUARD + 1) cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1, 1);
        repeat (3) begin
            cyc();
            checks++;
            if (dut_v() !== exp_v()) begin
                failures++; $display("FAIL reset_model got=%b exp=%b", dut_v(), exp_v());
            end
        end
        checks++;
        if (dut_v() !== 9'b000_1_01_11_0) begin
            failures++; $display("FAIL reset_const got=%b exp=%b", dut_v(), 9'b000_1_01_11_0);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        checks++;
        if (bus.st !== 1'b0 || bus.state_o !== 3'd0) begin
            failures++; $display("FAIL reset_release got st=%b state=%0d exp st=0 state=0", bus.st, bus.state_o);
        end
    endtask

    task automatic test_hold_hg();
        drive(0, 0, 0, 0, 1, 1);
        repeat (40) begin
            cyc();
            checks++;
            if (dut_v() !== exp_v()) begin
                failures++; $display("FAIL hold_hg_model got=%b exp=%b", dut_v(), exp_v());
            end
            checks++;
            if (dut_v() !== 9'b000_0_01_11_0) begin
                failures++; $display("FAIL hold_hg_const got=%b exp=%b", dut_v(), 9'b000_0_01_11_0);
            end
        end
    endtask

    task automatic test_car_cycle();
        drive(1, 0, 0, 0, 0, 1);
        cyc();
        checks++;
        if ({bus.state_o, bus.st, bus.hl} !== {3'd1, 1'b1, 2'b10}) begin
            failures++; $display("FAIL car_to_hy got=%b exp=%b", {bus.state_o, bus.st, bus.hl}, {3'd1, 1'b1, 2'b10});
        end
        drive(0, 0, 0, 0, 1, 0);
        repeat (GUARD + 1) begin
            cyc();
            checks++;
            if (dut_v() !== exp_v()) begin
                failures++; $display("FAIL car_cycle_model got=%b exp=%b", dut_v(), exp_v());
            end
        end
        checks++;
        if ({bus.state_o, bus.hl, bus.fl, bus.walk} !== {3'd2, 2'b11, 2'b01, 1'b0}) begin
            failures++; $display("FAIL car_fg got=%b exp=%b", {bus.state_o, bus.hl, bus.fl, bus.walk}, {3'd2, 2'b11, 2'b01, 1'b0});
        end
        repeat (2 * (GUARD + 1)) begin
            cyc();
            checks++;
            if (dut_v() !== exp_v()) begin
                failures++; $display("FAIL car_return_model got=%b exp=%b", dut_v(), exp_v());
            end
        end
        checks++;
        if (bus.state_o !== 3'd0) begin
            failures++; $display("FAIL car_back_hg got=%0d exp=0", bus.state_o);
        end
    endtask

    task automatic test_ped();
        drive(0, 1, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        repeat (GUARD) cyc();
        drive(0, 0, 0, 0, 0, 1);
        cyc();
        drive(0, 0, 0, 0, 1, 0);
        repeat (GUARD + 1 + 4) begin
            cyc();
            checks++;
            if (dut_v() !== exp_v()) begin
                failures++; $display("FAIL ped_model got=%b exp=%b", dut_v(), exp_v());
            end
        end
`ifdef PED_WALK_EN
        checks++;
        if ({bus.state_o, bus.walk} !== {3'd2, 1'b1}) begin
            failures++; $display("FAIL ped_walk_fg got=%b exp=%b", {bus.state_o, bus.walk}, {3'd2, 1'b1});
        end
`else
        checks++;
        if ({bus.state_o, bus.walk} !== {3'd0, 1'b0}) begin
            failures++; $display("FAIL ped_ignored got=%b exp=%b", {bus.state_o, bus.walk}, {3'd0, 1'b0});
        end
`endif
        drive(0, 0, 0, 0, 0, 1);
        cyc();
        checks++;
        if (dut_v() !== exp_v() || bus.walk !== 1'b0) begin
            failures++; $display("FAIL ped_leave_fg got=%b exp=%b", dut_v(), exp_v());
        end
        drive(0, 0, 0, 0, 1, 0);
        repeat (GUARD + 1) begin
            cyc();
            checks++;
            if (dut_v() !== exp_v()) begin
                failures++; $display("FAIL ped_return_model got=%b exp=%b", dut_v(), exp_v());
            end
        end
    endtask

    task automatic test_night_flash();
        logic [1:0] want_hl;
        do_reset();
        drive(1, 0, 0, 0, 0, 1);
        cyc();
        drive(1, 0, 0, 0, 1, 0);
        repeat (GUARD + 1) cyc();
        drive(1, 0, 1, 0, 1, 0);
        cyc();
        checks++;
        if ({bus.state_o, bus.hl, bus.fl} !== {3'd3, 2'b11, 2'b10}) begin
            failures++; $display("FAIL night_fy got=%b exp=%b", {bus.state_o, bus.hl, bus.fl}, {3'd3, 2'b11, 2'b10});
        end
        repeat (GUARD + 1) cyc();
        checks++;
        if ({bus.state_o, bus.hl, bus.fl} !== {3'd5, 2'b00, 2'b00}) begin
            failures++; $display("FAIL flash_entry got=%b exp=%b", {bus.state_o, bus.hl, bus.fl}, {3'd5, 2'b00, 2'b00});
        end
        for (int i = 1; i <= 6; i++) begin
            drive(0, 0, 1, 1, 0, 0);
            cyc();
            drive(0, 0, 1, 0, 0, 0);
            cyc();
            want_hl = (((i / FLASH_DIV) % 2) == 1) ? 2'b10 : 2'b00;
            checks++;
            if (bus.hl !== want_hl || dut_v() !== exp_v()) begin
                failures++; $display("FAIL flash_toggle tick=%0d got=%b exp_hl=%b model=%b", i, dut_v(), want_hl, exp_v());
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        checks++;
        if ({bus.state_o, bus.st, bus.hl, bus.fl} !== {3'd4, 1'b1, 2'b11, 2'b11}) begin
            failures++; $display("FAIL allred got=%b exp=%b", {bus.state_o, bus.st, bus.hl, bus.fl}, {3'd4, 1'b1, 2'b11, 2'b11});
        end
        drive(0, 0, 0, 0, 1, 0);
        repeat (GUARD + 1) begin
            cyc();
            checks++;
            if (dut_v() !== exp_v()) begin
                failures++; $display("FAIL allred_model got=%b exp=%b", dut_v(), exp_v());
            end
        end
        checks++;
        if (bus.state_o !== 3'd0) begin
            failures++; $display("FAIL allred_to_hg got=%0d exp=0", bus.state_o);
        end
    endtask

    task automatic test_guard();
        int st_count;
        do_reset();
        drive(1, 0, 0, 0, 0, 1);
        cyc();
        drive(1, 0, 0, 0, 1, 0);
        st_count = 0;
        for (int i = 1; i <= GUARD + 2; i++) begin
            cyc();
            st_count += int'(bus.st);
            checks++;
            if (i <= GUARD && {bus.state_o, bus.st} !== {3'd1, 1'b0}) begin
                failures++; $display("FAIL guard_hold cyc=%0d got=%b exp=%b", i, {bus.state_o, bus.st}, {3'd1, 1'b0});
            end else if (i == GUARD + 1 && {bus.state_o, bus.st} !== {3'd2, 1'b1}) begin
                failures++; $display("FAIL guard_fire cyc=%0d got=%b exp=%b", i, {bus.state_o, bus.st}, {3'd2, 1'b1});
            end else if (dut_v() !== exp_v()) begin
                failures++; $display("FAIL guard_model cyc=%0d got=%b exp=%b", i, dut_v(), exp_v());
            end
        end
        checks++;
        if (st_count != 1) begin
            failures++; $display("FAIL guard_st_count got=%0d exp=1", st_count);
        end
    endtask

    task automatic test_reset_in_flash();
        do_reset();
        drive(0, 0, 1, 0, 0, 0);
        cyc();
        drive(0, 0, 1, 1, 1, 0);
        repeat (GUARD + 2) cyc();
        checks++;
        if (bus.state_o !== 3'd5) begin
            failures++; $display("FAIL reach_flash got=%0d exp=5", bus.state_o);
        end
        rst_n = 1'b0;
        cyc();
        checks++;
        if (dut_v() !== 9'b000_1_01_11_0 || dut_v() !== exp_v()) begin
            failures++; $display("FAIL reset_in_flash got=%b exp=%b", dut_v(), 9'b000_1_01_11_0);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        checks++;
        if (bus.st !== 1'b0) begin
            failures++; $display("FAIL reset_in_flash_release got st=%b exp=0", bus.st);
        end
    endtask

    task automatic test_random();
        bit night_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(31) == 0) night_r = !night_r;
            rst_n = ($urandom_range(149) != 0);
            drive($urandom_range(1) == 1, $urandom_range(7) == 0, night_r,
                  $urandom_range(2) == 0, $urandom_range(1) == 1, $urandom_range(3) == 0);
            cyc();
            checks++;
            if (dut_v() !== exp_v()) begin
                failures++; $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_v(), exp_v());
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_hold_hg();
        test_car_cycle();
        test_ped();
        test_night_flash();
        test_guard();
        test_reset_in_flash();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Highway/farm-road intersection controller FSM. Sits directly downstream of the phase timer: consumes its short/long-elapsed flags (ts, tl) and drives its restart strobe (st).
- Decodes light colours for both roads, serves a latched pedestrian request and supports a night flashing mode.
- Runs on the system clock; tick is a 1-cycle, 1 Hz enable from the divider, used only for flashing.

Parameters:
- GUARD, 2, number of clk cycles after each st pulse during which ts/tl are ignored (timer settle window).
- FLASH_DIV, 1, number of tick pulses per flash half-period (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- car  input  1  farm-road vehicle sensor, level.
- ped_req  input  1  pedestrian button, 1-cycle pulse.
- night  input  1  night/flash mode request, level.
- tick  input  1  1 Hz enable pulse, one clk cycle wide.
- ts  input  1  timer: short interval elapsed (sticky until st).
- tl  input  1  timer: long interval elapsed (sticky until st).
- st  output  1  timer restart strobe, registered.
- hl  output  2  highway light: 00 off, 01 green, 10 yellow, 11 red.
- fl  output  2  farm-road light, same encoding.
- walk  output  1  pedestrian walk lamp.
- state_o  output  3  current state code for debug.

Behaviour:
- Reset (rst_n=0 at clk edge): state=HG, st=1 (held while in reset; timer stays cleared), hl=01, fl=11, walk=0, ped_pending=0, guard counter=GUARD, flash phase=0. First cycle after release: st=0.
- State codes: HG=0, HY=1, FG=2, FY=3, ALLRED=4, FLASH=5. Lights are decoded combinationally from the state register: HG 01/11, HY 10/11, FG 11/01, FY 11/10, ALLRED 11/11, FLASH per flash phase.
- Every state change produces st=1 for exactly the next clk cycle and reloads the guard counter to GUARD. ts/tl are treated as 0 while guard>0. No st is produced without a state change.
- Transitions, evaluated in priority order:
  - HG: night or (tl and (car or ped_pending)) -> HY.
  - HY: ts and night -> FLASH; ts -> FG.
  - FG: night or tl -> FY; ts and !car and !walk -> FY.
  - FY: ts and night -> FLASH; ts -> HG.
  - FLASH: !night -> ALLRED.
  - ALLRED: ts -> HG. Night reasserted here -> FLASH immediately; the ts check does not apply.
- Pedestrian handling:
  - ped_req sets ped_pending.
  - On the HY->FG transition, walk is loaded with ped_pending and ped_pending is cleared. A ped_req in that same cycle is served by this FG.
  - walk=1 for the whole FG state, then clears on leaving FG.
  - ped_req during FG or FY re-latches ped_pending for the next cycle round.
  - In FLASH, ped_pending is cleared and ped_req is ignored.
- FLASH:
  - Divider counts tick pulses; flash phase toggles every FLASH_DIV ticks.
  - phase=1: hl=10, fl=11. phase=0: hl=00, fl=00.
  - Phase and divider are cleared on FLASH entry, so the first visible phase is off.
- Simultaneous events:
  - night and tl together in HG -> HY, single transition.
  - ts arriving inside the guard window is ignored. Because ts is sticky, it is acted on at the first cycle after guard expires.
- Reset mid-phase: returns to the reset state on the next edge regardless of state; st is held high.

Optional Feature:
- PED_WALK_EN.
- Defined: pedestrian logic as above.
- Undefined: ped_pending is removed; walk is tied to 0; the HG exit condition is night or (tl and car); the FG early exit is ts and !car.
- All other behaviour is identical.

Test Plan:
- Reset, car=0, ts/tl driven high for 40 cycles -> state stays HG, hl=01, fl=11, st pulsed only during reset.
- From HG, car=1, tl=1 after guard -> st=1 one cycle, hl=10. Then ts=1 -> FG, fl=01, hl=11, walk=0.
- Pulse ped_req in HG with car=0, then tl=1 -> HY -> FG with walk=1. FG then exits on ts only after tl (walk blocks early exit). walk=0 in FY.
- In FG, raise night -> FY. Then ts -> FLASH with hl toggling 00/10 every FLASH_DIV=1 ticks. Drop night -> ALLRED (11/11). Then ts -> HG.
- ts asserted in the cycle immediately after st -> ignored for GUARD=2 cycles, transition occurs on cycle 3, exactly one st pulse.
- Assert rst_n=0 during FLASH -> next edge: state_o=0, hl=01, fl=11, st=1, walk=0.
